// File: rtl/cim_pkg.sv
// Shared widths, product type and mode decode for the tsmccim16x8x11m1 compute-in-memory macro.
package cim_pkg;

  localparam int unsigned CORE_NUM            = 16;
  localparam int unsigned XIN_BIT_WIDTH       = 11;
  localparam int unsigned MEM_BIT_WIDTH       = 8;
  localparam int unsigned MEM_ADR_WIDTH       = 2;
  localparam int unsigned MEM_DEPTH           = 1 << MEM_ADR_WIDTH;
  localparam int unsigned BANK_WIDTH          = $clog2(CORE_NUM);
  localparam int unsigned CORE_DOUT_BIT_WIDTH = XIN_BIT_WIDTH + MEM_BIT_WIDTH - 1;
  localparam int unsigned OUTPUT_BIT_WIDTH    = CORE_DOUT_BIT_WIDTH + BANK_WIDTH;
  localparam int unsigned TREE_LEVELS         = BANK_WIDTH;

  typedef logic signed [CORE_DOUT_BIT_WIDTH-1:0] core_product_t;

  typedef enum logic [1:0] {
    MODE_IDLE,
    MODE_COMPUTE,
    MODE_READBACK
  } cim_mode_t;

  // Compute wins over readback when both active-low enables are asserted.
  function automatic cim_mode_t decode_mode(input logic encb, input logic reb);
    if (!encb)
      return MODE_COMPUTE;
    else if (!reb)
      return MODE_READBACK;
    else
      return MODE_IDLE;
  endfunction

endpackage

// File: rtl/cim_core.sv
// One compute core: 4-word signed weight file with banked write port and
// a signed activation x weight product truncated to the core output width.
module cim_core
  import cim_pkg::*;
#(
  parameter int unsigned CORE_ID = 0
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            web,
  input  logic [BANK_WIDTH-1:0]           banka,
  input  logic [MEM_ADR_WIDTH-1:0]        adra,
  input  logic signed [MEM_BIT_WIDTH-1:0] d,
  input  logic [MEM_ADR_WIDTH-1:0]        adrb,
  input  logic signed [XIN_BIT_WIDTH-1:0] xin,
  output core_product_t                   product,
  output logic signed [MEM_BIT_WIDTH-1:0] word
);

  localparam logic [BANK_WIDTH-1:0] BANK_ID = BANK_WIDTH'(CORE_ID);

  logic signed [MEM_BIT_WIDTH-1:0] mem [MEM_DEPTH];
  logic signed [CORE_DOUT_BIT_WIDTH-1:0] xin_ext;
  logic signed [CORE_DOUT_BIT_WIDTH-1:0] word_ext;

  always_ff @(posedge clk) begin
    if (nrst) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++)
        mem[i] <= '0;
    end else if (!web && (banka == BANK_ID)) begin
      mem[adra] <= d;
    end
  end

  // Reads are combinational from the array, so a same-cycle write is seen one cycle later.
  assign word = mem[adrb];

  // Multiplying at the output width keeps only the low bits; -1024 * -128 wraps to the most negative value.
  assign xin_ext  = CORE_DOUT_BIT_WIDTH'(xin);
  assign word_ext = CORE_DOUT_BIT_WIDTH'(word);
  assign product  = xin_ext * word_ext;

endmodule

// File: rtl/tsmccim16x8x11m1.sv
// Compute-in-memory macro top: per-core multiply, adder-tree reduction,
// single-weight readback and the registered result Q.
module tsmccim16x8x11m1
  import cim_pkg::*;
(
  input  logic                                      CLK,
  input  logic                                      NRST,
  input  logic                                      ENCB,
  input  logic                                      WEB,
  input  logic [BANK_WIDTH-1:0]                     BANKA,
  input  logic [MEM_ADR_WIDTH-1:0]                  ADRA,
  input  logic signed [MEM_BIT_WIDTH-1:0]           D,
  input  logic                                      REB,
  input  logic [BANK_WIDTH-1:0]                     BANKB,
  input  logic [MEM_ADR_WIDTH-1:0]                  ADRB,
  input  logic [CORE_NUM*XIN_BIT_WIDTH-1:0]         XIN,
  output logic signed [OUTPUT_BIT_WIDTH-1:0]        Q
);

  core_product_t                   products [CORE_NUM];
  logic signed [MEM_BIT_WIDTH-1:0] words    [CORE_NUM];
  logic signed [OUTPUT_BIT_WIDTH-1:0] tree_sum;
  logic signed [OUTPUT_BIT_WIDTH-1:0] readback;
  cim_mode_t                       mode;

  for (genvar i = 0; i < CORE_NUM; i++) begin : g_core
    cim_core #(.CORE_ID(i)) u_core (
      .clk     (CLK),
      .nrst    (NRST),
      .web     (WEB),
      .banka   (BANKA),
      .adra    (ADRA),
      .d       (D),
      .adrb    (ADRB),
      .xin     (XIN[i*XIN_BIT_WIDTH +: XIN_BIT_WIDTH]),
      .product (products[i]),
      .word    (words[i])
    );
  end

  // Level 0 holds the sign-extended products; each further level halves the count.
  for (genvar l = 0; l <= TREE_LEVELS; l++) begin : g_lvl
    localparam int unsigned N = CORE_NUM >> l;
    logic signed [OUTPUT_BIT_WIDTH-1:0] sum [N];
    for (genvar j = 0; j < N; j++) begin : g_node
      if (l == 0) begin : g_leaf
        assign sum[j] = OUTPUT_BIT_WIDTH'(products[j]);
      end else begin : g_add
        assign sum[j] = g_lvl[l-1].sum[2*j] + g_lvl[l-1].sum[2*j+1];
      end
    end
  end

  assign tree_sum = g_lvl[TREE_LEVELS].sum[0];
  assign readback = OUTPUT_BIT_WIDTH'(words[BANKB]);
  assign mode     = decode_mode(ENCB, REB);

  always_ff @(posedge CLK) begin
    if (NRST) begin
      Q <= '0;
    end else begin
      case (mode)
        MODE_COMPUTE:  Q <= tree_sum;
        MODE_READBACK: Q <= readback;
        default:       Q <= Q;
      endcase
    end
  end

endmodule

// File: tb/tb_tsmccim16x8x11m1.sv
// Self-checking bench for tsmccim16x8x11m1: directed vectors with literal
// expectations plus an arithmetic reference model compared every cycle.
module tb_tsmccim16x8x11m1;

  localparam int NC = 16;
  localparam int XW = 11;

  logic          clk = 1'b0;
  logic          nrst, encb, web, reb;
  logic [3:0]    banka, bankb;
  logic [1:0]    adra, adrb;
  logic [7:0]    d;
  logic [NC*XW-1:0] xin;
  logic [21:0]   q;

  int total = 0;
  int bad   = 0;

  int mem_m [NC][4];
  int q_m = 0;
  bit model_ok = 0;

  always #5 clk = ~clk;

  tsmccim16x8x11m1 dut (
    .CLK   (clk),
    .NRST  (nrst),
    .ENCB  (encb),
    .WEB   (web),
    .BANKA (banka),
    .ADRA  (adra),
    .D     (d),
    .REB   (reb),
    .BANKB (bankb),
    .ADRB  (adrb),
    .XIN   (xin),
    .Q     (q)
  );

  // Interpret the low w bits of v as a two's-complement number.
  function automatic int sx(input int v, input int w);
    int m;
    m = v & ((1 << w) - 1);
    if (m >= (1 << (w - 1))) m = m - (1 << w);
    return m;
  endfunction

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%06h expected 0x%06h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: products from plain integer arithmetic, wrapped to 18 bits, summed mod 2^22.
  always @(posedge clk) begin
    int s, p;
    if (nrst === 1'b1) begin
      for (int i = 0; i < NC; i++)
        for (int a = 0; a < 4; a++)
          mem_m[i][a] = 0;
      q_m = 0;
      model_ok = 1;
    end else begin
      if (encb === 1'b0) begin
        s = 0;
        for (int i = 0; i < NC; i++) begin
          p = sx(int'(xin[i*XW +: XW]), XW) * mem_m[i][adrb];
          s = s + sx(p, 18);
        end
        q_m = s & 32'h3FFFFF;
      end else if (reb === 1'b0) begin
        q_m = mem_m[bankb][adrb] & 32'h3FFFFF;
      end
      if (web === 1'b0)
        mem_m[banka][adra] = sx(int'(d), 8);
    end
    #1;
    if (model_ok) check("model", q, q_m[21:0]);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    nrst = 1'b0; encb = 1'b1; web = 1'b1; reb = 1'b1;
  endtask

  task automatic set_x(input int core, input int val);
    xin[core*XW +: XW] = XW'(val);
  endtask

  task automatic write_w(input int core, input int adr, input int val);
    idle();
    web = 1'b0; banka = 4'(core); adra = 2'(adr); d = 8'(val);
    tick();
    web = 1'b1;
  endtask

  initial begin
    nrst = 1'b1; encb = 1'b1; web = 1'b1; reb = 1'b1;
    banka = '0; bankb = '0; adra = '0; adrb = '0; d = '0; xin = '0;
    @(negedge clk);
    tick();
    tick();
    check("reset_q", q, 22'h000000);

    // Compute after reset: all weights are zero.
    idle();
    for (int i = 0; i < NC; i++) set_x(i, int'($urandom_range(0, 2047)));
    encb = 1'b0; adrb = 2'(1);
    tick();
    check("compute_zero_weights", q, 22'h000000);

    write_w(0, 1, 8'h05);
    xin = '0; set_x(0, 3); encb = 1'b0; adrb = 2'(1);
    tick();
    check("basic_3x5", q, 22'h00000F);

    // Reset while compute is requested wins and clears the weights.
    nrst = 1'b1;
    tick();
    check("reset_mid_compute", q, 22'h000000);
    nrst = 1'b0;
    tick();
    check("weights_cleared", q, 22'h000000);

    for (int i = 0; i < NC; i++) write_w(i, 2, 8'h7F);
    for (int i = 0; i < NC; i++) set_x(i, 11'h3FF);
    encb = 1'b0; adrb = 2'(2);
    tick();
    check("all_cores_max_pos", q, 22'h1FB810);

    write_w(5, 0, 8'hFE);
    xin = '0; set_x(5, 5); encb = 1'b0; adrb = 2'(0);
    tick();
    check("negative_weight", q, 22'h3FFFF6);

    write_w(3, 0, 8'h80);
    xin = '0; set_x(3, 11'h400); encb = 1'b0; adrb = 2'(0);
    tick();
    check("wrap_min_x_min", q, 22'h3E0000);

    write_w(9, 3, 8'h90);
    xin = '0; set_x(9, 2);
    reb = 1'b0; encb = 1'b1; bankb = 4'(9); adrb = 2'(3);
    tick();
    check("readback_core9", q, 22'h3FFF90);
    encb = 1'b0;
    tick();
    check("compute_over_readback", q, 22'h3FFF20);
    encb = 1'b1; reb = 1'b1; set_x(9, 7); bankb = 4'(0);
    tick();
    check("idle_hold", q, 22'h3FFF20);
    tick();
    check("idle_hold2", q, 22'h3FFF20);

    // Same-cycle write and compute on one word sees the old weight.
    write_w(0, 1, 8'h10);
    xin = '0; set_x(0, 1);
    web = 1'b0; banka = 4'(0); adra = 2'(1); d = 8'h20;
    encb = 1'b0; adrb = 2'(1);
    tick();
    check("rdw_old_value", q, 22'h000010);
    web = 1'b1;
    tick();
    check("rdw_new_value", q, 22'h000020);

    // Mixed traffic checked only by the model.
    for (int n = 0; n < 60; n++) begin
      nrst  = ($urandom_range(0, 29) == 0);
      encb  = 1'($urandom);
      web   = 1'($urandom);
      reb   = 1'($urandom);
      banka = 4'($urandom);
      bankb = 4'($urandom);
      adra  = 2'($urandom);
      adrb  = 2'($urandom);
      d     = 8'($urandom);
      for (int i = 0; i < NC; i++) set_x(i, int'($urandom_range(0, 2047)));
      tick();
    end

    idle();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
